// File: rtl/shift_reg_seq.sv
// ============================================================================
// Module   : shift_reg_seq
// Brief    : Parametrised load/shift register with four shift modes, a manual
//            single step, and a sequencer that runs an N-step shift on Start.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_reg_seq #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Load,
   input  logic [WIDTH-1:0] D,
   input  logic             Shift_En,
   input  logic             Start,
   input  logic [AMT_W-1:0] Amount,
   input  logic [1:0]       Mode,
   input  logic             Shift_In,
   output logic [WIDTH-1:0] Data_Out,
   output logic             Shift_Out,
   output logic             Busy,
   output logic             Done,
   output logic [AMT_W-1:0] Remaining
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_data;
   logic [AMT_W-1:0] r_remaining;
   logic [1:0]       r_mode;
   logic             r_busy;
   logic             r_done;
   logic [1:0]       w_out_mode;

   function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] d,
                                                input logic [1:0]       m,
                                                input logic             s);
      case (m)
         2'b00:   f_step = {s, d[WIDTH-1:1]};
         2'b01:   f_step = {d[WIDTH-1], d[WIDTH-1:1]};
         2'b10:   f_step = {d[WIDTH-2:0], s};
         default: f_step = {d[0], d[WIDTH-1:1]};
      endcase
   endfunction

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state     <= ST_IDLE;
         r_data      <= '0;
         r_remaining <= '0;
         r_mode      <= 2'b00;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (Load) begin
                  r_data <= D;
               end else if (Start) begin
                  r_mode      <= Mode;
                  r_remaining <= Amount;
                  r_busy      <= 1'b1;
                  if (Amount != '0) begin
                     r_state <= ST_SHIFT;
                  end else begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end
               end else if (Shift_En) begin
                  r_data <= f_step(r_data, Mode, Shift_In);
               end
            end
            ST_SHIFT: begin
               // Mode stays latched for the whole sequence; Shift_In is live.
               r_data      <= f_step(r_data, r_mode, Shift_In);
               r_remaining <= r_remaining - AMT_W'(1);
               if (r_remaining == AMT_W'(1)) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign w_out_mode = r_busy ? r_mode : Mode;
   assign Shift_Out  = (w_out_mode == 2'b10) ? r_data[WIDTH-1] : r_data[0];
   assign Data_Out   = r_data;
   assign Remaining  = r_remaining;
   assign Busy       = r_busy;
   assign Done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_seq.sv
// ============================================================================
// Module   : tb_shift_reg_seq
// Brief    : Directed and random checks of shift_reg_seq against a reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_reg_seq;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       Load = 1'b0;
   logic [7:0] D = '0;
   logic       Shift_En = 1'b0;
   logic       Start = 1'b0;
   logic [3:0] Amount = '0;
   logic [1:0] Mode = '0;
   logic       Shift_In = 1'b0;
   logic [7:0] Data_Out;
   logic       Shift_Out;
   logic       Busy;
   logic       Done;
   logic [3:0] Remaining;

   shift_reg_seq #(.WIDTH(8), .AMT_W(4)) dut (
      .Clk(Clk), .Reset(Reset), .Load(Load), .D(D), .Shift_En(Shift_En),
      .Start(Start), .Amount(Amount), .Mode(Mode), .Shift_In(Shift_In),
      .Data_Out(Data_Out), .Shift_Out(Shift_Out), .Busy(Busy), .Done(Done),
      .Remaining(Remaining)
   );

   always #5 Clk = ~Clk;

   int n_total = 0;
   int n_bad   = 0;

   // Reference model state
   logic [7:0] m_data = '0;
   logic [3:0] m_left = '0;
   logic       m_shifting = 1'b0;
   logic       m_done = 1'b0;
   logic [1:0] m_mode = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] m_step(input logic [7:0] d, input logic [1:0] m, input logic s);
      case (m)
         2'd0:    return (d >> 1) | (s ? 8'h80 : 8'h00);
         2'd1:    return 8'($signed(d) >>> 1);
         2'd2:    return (d << 1) | {7'd0, s};
         default: return (d >> 1) | (d << 7);
      endcase
   endfunction

   // One clock: drive inputs, check Shift_Out before the edge, advance model, check after.
   task automatic cycle(input logic rst, input logic ld, input logic [7:0] d,
                        input logic se, input logic st, input logic [3:0] amt,
                        input logic [1:0] md, input logic si);
      logic [1:0] em;
      Reset = rst; Load = ld; D = d; Shift_En = se; Start = st;
      Amount = amt; Mode = md; Shift_In = si;
      #1;
      em = (m_shifting || m_done) ? m_mode : md;
      check("shift_out", Shift_Out, (em == 2'd2) ? m_data[7] : m_data[0]);
      if (rst) begin
         m_data = '0; m_left = '0; m_shifting = 1'b0; m_done = 1'b0;
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (m_shifting) begin
         m_data = m_step(m_data, m_mode, si);
         m_left = m_left - 4'd1;
         if (m_left == 4'd0) begin
            m_shifting = 1'b0;
            m_done = 1'b1;
         end
      end else if (ld) begin
         m_data = d;
      end else if (st) begin
         m_mode = md;
         m_left = amt;
         if (amt == 4'd0) m_done = 1'b1;
         else m_shifting = 1'b1;
      end else if (se) begin
         m_data = m_step(m_data, md, si);
      end
      @(posedge Clk);
      #1;
      check("data_out", Data_Out, m_data);
      check("busy", Busy, m_shifting | m_done);
      check("done", Done, m_done);
      check("remaining", Remaining, m_left);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0);
   endtask

   initial begin
      logic [8:0] rot_seq;
      rot_seq = 9'b110000001;   // bit k = Shift_Out before step k

      @(posedge Clk); #1;
      // Reset dominates Load
      cycle(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0);
      check("rst_data", Data_Out, 8'h00);
      check("rst_busy", Busy, 1'b0);
      check("rst_done", Done, 1'b0);
      check("rst_rem", Remaining, 4'd0);

      // Arithmetic right by 3, with Load attempted during SHIFT
      cycle(1'b0, 1'b1, 8'hB4, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd3, 2'd1, 1'b0);
      check("asr_rem3", Remaining, 4'd3);
      cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0);
      cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0);
      check("asr_done_early", Done, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0);
      check("asr_data", Data_Out, 8'hF6);
      check("asr_done", Done, 1'b1);
      idle(1);
      check("asr_busy_fall", Busy, 1'b0);
      check("asr_done_once", Done, 1'b0);

      // Rotate right by 9 with explicit Shift_Out sequence
      cycle(1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd9, 2'd3, 1'b0);
      for (int k = 0; k < 9; k++) begin
         check("rot_shift_out", Shift_Out, rot_seq[k]);
         cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0);
      end
      check("rot_data", Data_Out, 8'hC0);
      check("rot_done", Done, 1'b1);
      idle(1);

      // Left with serial fill; Mode change mid-sequence ignored
      cycle(1'b0, 1'b1, 8'h0F, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd2, 2'd2, 1'b1);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'd0, 1'b1);
      check("left_data", Data_Out, 8'h3F);
      idle(1);

      // Amount = 0
      cycle(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd0, 2'd0, 1'b1);
      check("amt0_done", Done, 1'b1);
      check("amt0_data", Data_Out, 8'h5A);
      idle(1);
      check("amt0_busy", Busy, 1'b0);

      // Load beats Start
      cycle(1'b0, 1'b1, 8'h3C, 1'b0, 1'b1, 4'd4, 2'd0, 1'b0);
      check("ldst_data", Data_Out, 8'h3C);
      check("ldst_busy", Busy, 1'b0);

      // Abort mid-sequence
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4'd5, 2'd3, 1'b0);
      idle(2);
      cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 2'd0, 1'b0);
      check("abort_data", Data_Out, 8'h00);
      check("abort_busy", Busy, 1'b0);
      for (int k = 0; k < 6; k++) begin
         idle(1);
         check("abort_no_done", Done, 1'b0);
      end

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 59) == 0),
               ($urandom_range(0, 7) == 0),
               8'($urandom),
               ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 5) == 0),
               4'($urandom),
               2'($urandom),
               1'($urandom));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
